// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy scoreboard and reservations.
// Ports: two read ports (A has base-address zero mode), one write, one reserve.
module regfile_scoreboard #(
  parameter  int WIDTH  = 32,
  parameter  int NREGS  = 16,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [AW-1:0]    ra_addr,
  input  logic             ra_ba,
  output logic [WIDTH-1:0] ra_data,
  output logic             ra_busy,
  input  logic [AW-1:0]    rb_addr,
  output logic [WIDTH-1:0] rb_data,
  output logic             rb_busy,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  output logic             rsv_ok,
  output logic [AW:0]      busy_cnt,
  output logic             all_idle,
  output logic             rsv_err
);

  localparam logic       BYP = (BYPASS != 0);
  localparam logic [AW:0] ONE = 1;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             err_q, err_d;

  logic ra_hit, rb_hit, ra_zero;
  logic wr_rsv_same, inc, dec;

  always_comb begin
    ra_hit  = BYP & wr_en & (wr_addr == ra_addr);
    rb_hit  = BYP & wr_en & (wr_addr == rb_addr);
    ra_zero = ra_ba & (ra_addr == '0);

    ra_data = '0;
    if (clr && !ra_zero) begin
      ra_data = ra_hit ? wr_data : regs_q[ra_addr];
    end
    rb_data = '0;
    if (clr) begin
      rb_data = rb_hit ? wr_data : regs_q[rb_addr];
    end

    ra_busy = clr & busy_q[ra_addr] & ~ra_hit & ~ra_zero;
    rb_busy = clr & busy_q[rb_addr] & ~rb_hit;

    wr_rsv_same = wr_en & (wr_addr == rsv_addr);
    rsv_ok = clr & rsv_en & (~busy_q[rsv_addr] | wr_rsv_same);

    // Count tracks popcount: only a 0->1 set or an un-overridden 1->0 clear moves it.
    inc = rsv_ok & ~busy_q[rsv_addr];
    dec = wr_en & busy_q[wr_addr] & ~(rsv_ok & wr_rsv_same);
  end

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_en) begin
      regs_d[wr_addr] = wr_data;
      busy_d[wr_addr] = 1'b0;
    end
    if (rsv_ok) begin
      busy_d[rsv_addr] = 1'b1;
    end

    cnt_d = cnt_q;
    if (inc && !dec) begin
      cnt_d = cnt_q + ONE;
    end else if (dec && !inc) begin
      cnt_d = cnt_q - ONE;
    end

    err_d = err_q | (rsv_en & ~rsv_ok);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign busy_cnt = cnt_q;
  assign all_idle = (cnt_q == '0);
  assign rsv_err  = err_q;

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of every register.
REQ-002 SHALL have parameter NREGS, default 16, register count; power of two, >=2; AW = clog2(NREGS).
REQ-003 SHALL have parameter BYPASS, default 1; 1 = same-cycle write-to-read forwarding enabled.
REQ-004 SHALL have ports:
- clk  in  1  rising-edge clock.
- clr  in  1  asynchronous, active-low reset.
- ra_addr  in  AW  read port A address.
- ra_ba  in  1  base-address mode; forces read port A to zero when ra_addr==0.
- ra_data  out  WIDTH  read port A data.
- ra_busy  out  1  port A register pending.
- rb_addr  in  AW  read port B address.
- rb_data  out  WIDTH  read port B data.
- rb_busy  out  1  port B register pending.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write address.
- wr_data  in  WIDTH  write data.
- rsv_en  in  1  reservation request.
- rsv_addr  in  AW  register to reserve.
- rsv_ok  out  1  reservation accepted this cycle.
- busy_cnt  out  AW+1  count of pending registers.
- all_idle  out  1  no register pending.
- rsv_err  out  1  sticky rejected-reservation flag.

Function
REQ-005 SHALL hold NREGS registers of WIDTH bits plus an NREGS-bit busy vector.
REQ-006 SHALL write wr_data into register wr_addr on the rising clk edge when wr_en=1; all addresses, including 0, are writable.
REQ-007 SHALL drive ra_data/rb_data combinationally from the addressed register.
REQ-008 SHALL, when BYPASS=1 and wr_en=1 and wr_addr equals a read address, drive that port with wr_data in the same cycle; BYPASS=0 returns the stored value.
REQ-009 SHALL drive ra_data=0 when ra_ba=1 and ra_addr=0, overriding bypass; rb_data is unaffected by ra_ba.
REQ-010 SHALL drive rsv_ok = rsv_en & (!busy[rsv_addr] | (wr_en & wr_addr==rsv_addr)), combinationally.
REQ-011 SHALL set busy[rsv_addr] on the clock edge when rsv_ok=1.
REQ-012 SHALL clear busy[wr_addr] on the clock edge when wr_en=1, unless the same edge sets it per REQ-011; set wins.
REQ-013 SHALL leave the busy vector unchanged when a write targets a non-busy register.
REQ-014 SHALL drive ra_busy = busy[ra_addr] & !(BYPASS & wr_en & wr_addr==ra_addr), and rb_busy likewise.
REQ-015 SHALL force ra_busy=0 when ra_ba=1 and ra_addr=0.
REQ-016 SHALL maintain busy_cnt as a registered population count of the busy vector, updated on the same edge as the vector: +1 on set only, -1 on clear only, unchanged on set+clear of different registers and on set-wins collisions.
REQ-017 SHALL drive all_idle = (busy_cnt==0).
REQ-018 SHALL set rsv_err on the edge where rsv_en=1 and rsv_ok=0; it stays set until reset.
REQ-019 SHALL never let busy_cnt exceed NREGS or go below 0; a full vector rejects every further reservation unless it coincides with a write to the requested register.

Reset
REQ-020 SHALL, while clr=0 and independent of clk, force every register, busy bit, busy_cnt and rsv_err to 0.
REQ-021 SHALL, during reset, drive rsv_ok=0, ra_busy=0, rb_busy=0, all_idle=1 and ra_data/rb_data=0.
REQ-022 SHALL, on reset assertion mid-reservation, discard all pending state; the first edge after clr returns to 1 behaves as from power-up.

Verification
REQ-023 Write R3=0x0000_00A5, then read ra_addr=3 and rb_addr=3 -> both ports return 0x0000_00A5. Same-cycle write R3=0x1234 with ra_addr=3 -> ra_data=0x1234 (BYPASS=1) or 0x00A5 (BYPASS=0).
REQ-024 Write R0=0xDEAD_BEEF; ra_addr=0, ra_ba=1 -> ra_data=0; ra_ba=0 -> 0xDEADBEEF. rb_addr=0 -> 0xDEADBEEF regardless of ra_ba.
REQ-025 Reserve R5 -> rsv_ok=1, busy_cnt=1, ra_busy=1 for ra_addr=5. Reserve R5 again -> rsv_ok=0, rsv_err=1. Write R5 -> busy_cnt=0, all_idle=1.
REQ-026 Busy R7 and R2; same edge write R7 and reserve R7 -> busy[7] stays 1, busy_cnt stays 2, rsv_ok=1, rsv_err stays 0.
REQ-027 Reserve all 16 registers -> busy_cnt=16. Reserve R9 without a write -> rejected, count stays 16. Reserve R9 alongside a write to R9 -> accepted, count stays 16.
REQ-028 Hold busy_cnt=4 and rsv_err=1, then pulse clr=0 between clock edges -> all outputs reset immediately; registers read 0 afterwards.
